// File: rtl/mips_mem_pkg.sv
// Shared constants and types for the MIPS data-side memory/MMIO responder.
// MMIO register byte offsets within the 256-byte window, STATUS bit
// positions, and the address-region decode type.
package mips_mem_pkg;

  localparam logic [7:0] OFF_TX     = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_CYCLE  = 8'h08;
  localparam logic [7:0] OFF_GPIO   = 8'h0C;

  // STATUS layout: [3:0] count, [4] empty, [5] full, [8] overflow, [9] fault
  localparam int ST_EMPTY = 4;
  localparam int ST_FULL  = 5;
  localparam int ST_OVF   = 8;
  localparam int ST_FLT   = 9;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_MMIO,
    RGN_NONE
  } region_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read port.
// Ports: push/wdata enqueue, pop dequeues head, rdata = head entry,
// full/empty/count status. Async active-low reset empties the FIFO
// (storage itself is not cleared). A push while full is accepted only
// when a pop frees a slot in the same cycle; a pop while empty is ignored.
module sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign count   = cnt;
  assign rdata   = mem[rp];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/mips_dmem_mmio.sv
// Data-side responder for the single-cycle MIPS core.
// Ports: mem_addr/mem_write/mem_we from the core, mem_read combinational
// load data back; tx_data/tx_valid/tx_ready console byte stream out of the
// TX FIFO; gpio_out GPIO register; bus_fault sticky fault (STATUS[9]).
// Map: word RAM at 0..RAM_WORDS*4-1, MMIO window at MMIO_BASE with TX,
// STATUS, CYCLE and GPIO registers. Misaligned or unmapped stores are
// dropped and raise the fault flag; loads never fault.
module mips_dmem_mmio
  import mips_mem_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 256,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_FF00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write,
  input  logic        mem_we,
  output logic [31:0] mem_read,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] gpio_out,
  output logic        bus_fault
);
  localparam int unsigned RAW       = $clog2(RAM_WORDS);
  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0]    ram [RAM_WORDS];
  region_e        rgn;
  logic [7:0]     off;
  logic [RAW-1:0] ram_idx;
  logic           aligned, wr_ok, wr_bad;
  logic           push, pop, full, empty;
  logic [CW-1:0]  count;
  logic           st_wr, cyc_wr, gpio_wr;
  logic           ovf_set, ovf_clr, flt_clr;
  logic           ovf_q, flt_q;
  logic [31:0]    cycle_q, gpio_q, status;

  // Word offset ignores the byte lane so misaligned loads see the aligned word.
  assign off     = {mem_addr[7:2], 2'b00};
  assign ram_idx = mem_addr[RAW+1:2];
  assign aligned = (mem_addr[1:0] == 2'b00);

  always_comb begin
    rgn = RGN_NONE;
    if (mem_addr < RAM_BYTES)
      rgn = RGN_RAM;
    else if (mem_addr[31:8] == MMIO_BASE[31:8] && off <= OFF_GPIO)
      rgn = RGN_MMIO;
  end

  assign wr_ok   = mem_we && aligned && (rgn != RGN_NONE);
  assign wr_bad  = mem_we && !wr_ok;
  assign push    = wr_ok && (rgn == RGN_MMIO) && (off == OFF_TX);
  assign st_wr   = wr_ok && (rgn == RGN_MMIO) && (off == OFF_STATUS);
  assign cyc_wr  = wr_ok && (rgn == RGN_MMIO) && (off == OFF_CYCLE);
  assign gpio_wr = wr_ok && (rgn == RGN_MMIO) && (off == OFF_GPIO);

  assign pop     = tx_valid && tx_ready;
  // A simultaneous pop makes room, so a push into a full FIFO is not an overflow.
  assign ovf_set = push && full && !pop;
  assign ovf_clr = st_wr && mem_write[ST_OVF];
  assign flt_clr = st_wr && mem_write[ST_FLT];

  sync_fifo #(
    .W     (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (mem_write[7:0]),
    .pop   (pop),
    .rdata (tx_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign tx_valid  = !empty;
  assign gpio_out  = gpio_q;
  assign bus_fault = flt_q;

  always_comb begin
    status           = '0;
    status[3:0]      = 4'(count);
    status[ST_EMPTY] = empty;
    status[ST_FULL]  = full;
    status[ST_OVF]   = ovf_q;
    status[ST_FLT]   = flt_q;
  end

  always_comb begin
    mem_read = '0;
    case (rgn)
      RGN_RAM:  mem_read = ram[ram_idx];
      RGN_MMIO: begin
        case (off)
          OFF_STATUS: mem_read = status;
          OFF_CYCLE:  mem_read = cycle_q;
          OFF_GPIO:   mem_read = gpio_q;
          default:    mem_read = '0;
        endcase
      end
      default:  mem_read = '0;
    endcase
  end

  // Sticky flags: a set in the same cycle as a W1C clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q   <= 1'b0;
      flt_q   <= 1'b0;
      cycle_q <= '0;
      gpio_q  <= '0;
    end else begin
      ovf_q   <= ovf_set | (ovf_q & ~ovf_clr);
      flt_q   <= wr_bad  | (flt_q & ~flt_clr);
      cycle_q <= cyc_wr ? '0 : cycle_q + 32'd1;
      if (gpio_wr) gpio_q <= mem_write;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && rgn == RGN_RAM) ram[ram_idx] <= mem_write;
  end

endmodule

// File: tb/tb_mips_dmem_mmio.sv
module tb_mips_dmem_mmio;
  localparam int          RAM_WORDS  = 256;
  localparam int          FIFO_DEPTH = 8;
  localparam logic [31:0] BASE       = 32'h0000_FF00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_write = '0;
  logic        mem_we = 1'b0;
  logic        tx_ready = 1'b0;
  logic [31:0] mem_read;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [31:0] gpio_out;
  logic        bus_fault;

  int n_checks = 0;
  int n_fail   = 0;

  mips_dmem_mmio #(
    .RAM_WORDS  (RAM_WORDS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MMIO_BASE  (BASE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_addr  (mem_addr),
    .mem_write (mem_write),
    .mem_we    (mem_we),
    .mem_read  (mem_read),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .gpio_out  (gpio_out),
    .bus_fault (bus_fault)
  );

  always #5 clk = ~clk;

  // Behavioural reference: RAM array, byte queue for the console, plain
  // registers for GPIO/cycle and the two sticky flags.
  logic [31:0] m_ram [RAM_WORDS];
  logic [7:0]  m_q [$];
  logic [31:0] m_gpio = '0;
  logic [31:0] m_cyc = '0;
  bit          m_ovf = 1'b0;
  bit          m_flt = 1'b0;

  function automatic logic [31:0] m_status();
    int n = m_q.size();
    return {22'b0, m_flt, m_ovf, 2'b00, (n == FIFO_DEPTH), (n == 0), 4'(n)};
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [31:0] w = {a[31:2], 2'b00};
    if (w < RAM_WORDS * 4) return m_ram[int'(w >> 2)];
    if (w == BASE + 4)  return m_status();
    if (w == BASE + 8)  return m_cyc;
    if (w == BASE + 12) return m_gpio;
    return 32'h0;
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_gpio = '0;
    m_cyc  = '0;
    m_ovf  = 1'b0;
    m_flt  = 1'b0;
  endfunction

  // Applies one clock edge worth of effects for the inputs currently driven.
  task automatic model_tick();
    logic [31:0] a = mem_addr;
    bit ovf_set = 0, flt_set = 0, ovf_clr = 0, flt_clr = 0, cyc_clr = 0;
    if (m_q.size() != 0 && tx_ready) void'(m_q.pop_front());
    if (mem_we) begin
      if (a[1:0] != 2'b00)              flt_set = 1;
      else if (a < RAM_WORDS * 4)       m_ram[int'(a >> 2)] = mem_write;
      else if (a == BASE) begin
        if (m_q.size() < FIFO_DEPTH) m_q.push_back(mem_write[7:0]);
        else ovf_set = 1;
      end
      else if (a == BASE + 4) begin
        ovf_clr = mem_write[8];
        flt_clr = mem_write[9];
      end
      else if (a == BASE + 8)           cyc_clr = 1;
      else if (a == BASE + 12)          m_gpio = mem_write;
      else                              flt_set = 1;
    end
    m_cyc = cyc_clr ? 32'h0 : m_cyc + 32'd1;
    m_ovf = ovf_set | (m_ovf & !ovf_clr);
    m_flt = flt_set | (m_flt & !flt_clr);
  endtask

  // One bus cycle: the previous inputs commit at the rising edge, new inputs
  // are applied at the falling edge and settle before the caller samples.
  task automatic drive(input logic [31:0] a, input logic we,
                       input logic [31:0] wd, input logic rdy);
    @(posedge clk);
    model_tick();
    @(negedge clk);
    mem_addr  = a;
    mem_we    = we;
    mem_write = wd;
    tx_ready  = rdy;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_we = 1'b0; mem_addr = '0; mem_write = '0; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    n_checks++;
    if (gpio_out !== 32'h0) begin n_fail++; $display("FAIL reset_gpio got=%h exp=0", gpio_out); end
    n_checks++;
    if (bus_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got=%b exp=0", bus_fault); end
    drive(BASE + 4, 0, 0, 0);
    n_checks++;
    if (mem_read !== 32'h10) begin n_fail++; $display("FAIL reset_status got=%h exp=%h", mem_read, 32'h10); end
    drive(BASE + 8, 0, 0, 0);
    n_checks++;
    if (mem_read !== m_cyc) begin n_fail++; $display("FAIL reset_cycle got=%h exp=%h", mem_read, m_cyc); end
  endtask

  task automatic test_ram();
    drive(32'h0, 1, 32'h14, 0);
    drive(32'h0, 0, 0, 0);
    n_checks++;
    if (mem_read !== 32'h14) begin n_fail++; $display("FAIL ram_load0 got=%h exp=%h", mem_read, 32'h14); end
    drive(32'h4, 1, 32'h8, 0);
    drive(32'h4, 0, 0, 0);
    n_checks++;
    if (mem_read !== 32'h8) begin n_fail++; $display("FAIL ram_load4 got=%h exp=%h", mem_read, 32'h8); end
    drive(32'h0, 0, 0, 0);
    n_checks++;
    if (mem_read !== exp_read(32'h0)) begin n_fail++; $display("FAIL ram_reload0 got=%h exp=%h", mem_read, exp_read(32'h0)); end
  endtask

  task automatic test_tx_basic();
    drive(BASE, 1, 32'h48, 0);
    drive(BASE, 1, 32'h69, 0);
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h48) begin n_fail++; $display("FAIL tx_head1 got=%b/%h exp=1/48", tx_valid, tx_data); end
    drive(BASE + 4, 0, 0, 0);
    n_checks++;
    if (mem_read !== 32'h2) begin n_fail++; $display("FAIL tx_status2 got=%h exp=%h", mem_read, 32'h2); end
    n_checks++;
    if (tx_data !== 8'h48) begin n_fail++; $display("FAIL tx_hold got=%h exp=48", tx_data); end
    drive(BASE + 4, 0, 0, 1);
    n_checks++;
    if (tx_data !== 8'h48) begin n_fail++; $display("FAIL tx_drain0 got=%h exp=48", tx_data); end
    drive(BASE + 4, 0, 0, 1);
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h69) begin n_fail++; $display("FAIL tx_drain1 got=%b/%h exp=1/69", tx_valid, tx_data); end
    drive(BASE + 4, 0, 0, 0);
    n_checks++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_empty got=%b exp=0", tx_valid); end
  endtask

  task automatic test_overflow();
    logic [7:0] b [9];
    for (int i = 0; i < 9; i++) begin
      b[i] = 8'($urandom);
      drive(BASE, 1, {24'h0, b[i]}, 0);
    end
    drive(BASE + 4, 0, 0, 0);
    n_checks++;
    if (mem_read !== 32'h128) begin n_fail++; $display("FAIL ovf_status got=%h exp=%h", mem_read, 32'h128); end
    for (int i = 0; i < 8; i++) begin
      drive(BASE + 4, 0, 0, 1);
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== b[i]) begin
        n_fail++; $display("FAIL ovf_drain[%0d] got=%b/%h exp=1/%h", i, tx_valid, tx_data, b[i]);
      end
    end
    drive(BASE + 4, 1, 32'h100, 0);
    n_checks++;
    if (mem_read !== 32'h110) begin n_fail++; $display("FAIL ovf_pre_clr got=%h exp=%h", mem_read, 32'h110); end
    drive(BASE + 4, 0, 0, 0);
    n_checks++;
    if (mem_read !== 32'h10) begin n_fail++; $display("FAIL ovf_cleared got=%h exp=%h", mem_read, 32'h10); end
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < 8; i++) drive(BASE, 1, 32'(i + 1), 0);
    drive(BASE, 1, 32'hAA, 1);
    n_checks++;
    if (tx_data !== 8'h01) begin n_fail++; $display("FAIL full_head got=%h exp=01", tx_data); end
    drive(BASE + 4, 0, 0, 0);
    n_checks++;
    if (mem_read !== 32'h28) begin n_fail++; $display("FAIL full_pushpop_status got=%h exp=%h", mem_read, 32'h28); end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] e = (i < 7) ? 8'(i + 2) : 8'hAA;
      drive(BASE + 4, 0, 0, 1);
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== e) begin
        n_fail++; $display("FAIL full_drain[%0d] got=%b/%h exp=1/%h", i, tx_valid, tx_data, e);
      end
    end
    drive(BASE + 4, 0, 0, 0);
    n_checks++;
    if (mem_read !== 32'h10) begin n_fail++; $display("FAIL full_drained got=%h exp=%h", mem_read, 32'h10); end
  endtask

  task automatic test_fault();
    drive(32'h2000, 1, 32'hDEAD_BEEF, 0);
    drive(32'h2000, 0, 0, 0);
    n_checks++;
    if (bus_fault !== 1'b1) begin n_fail++; $display("FAIL fault_unmapped got=%b exp=1", bus_fault); end
    n_checks++;
    if (mem_read !== 32'h0) begin n_fail++; $display("FAIL unmapped_read got=%h exp=0", mem_read); end
    drive(BASE + 4, 1, 32'h200, 0);
    n_checks++;
    if (mem_read !== 32'h210) begin n_fail++; $display("FAIL fault_status got=%h exp=%h", mem_read, 32'h210); end
    drive(32'h4, 0, 0, 0);
    n_checks++;
    if (bus_fault !== 1'b0) begin n_fail++; $display("FAIL fault_w1c got=%b exp=0", bus_fault); end
    drive(32'h6, 1, 32'hFFFF_FFFF, 0);
    drive(32'h6, 0, 0, 0);
    n_checks++;
    if (bus_fault !== 1'b1) begin n_fail++; $display("FAIL fault_misaligned got=%b exp=1", bus_fault); end
    n_checks++;
    if (mem_read !== 32'h8) begin n_fail++; $display("FAIL misaligned_keep got=%h exp=%h", mem_read, 32'h8); end
    drive(BASE + 4, 1, 32'h200, 0);
    drive(BASE + 16, 0, 0, 0);
    n_checks++;
    if (mem_read !== 32'h0 || bus_fault !== 1'b0) begin
      n_fail++; $display("FAIL unmapped_load got=%h/%b exp=0/0", mem_read, bus_fault);
    end
  endtask

  task automatic test_cycle();
    drive(BASE + 8, 1, 32'd123, 0);
    drive(BASE + 8, 0, 0, 0);
    n_checks++;
    if (mem_read !== 32'h0) begin n_fail++; $display("FAIL cycle_zero got=%h exp=0", mem_read); end
    repeat (4) drive(BASE + 8, 0, 0, 0);
    drive(BASE + 8, 0, 0, 0);
    n_checks++;
    if (mem_read !== 32'd5) begin n_fail++; $display("FAIL cycle_five got=%h exp=5", mem_read); end
  endtask

  task automatic test_random();
    logic [31:0] a, wd;
    logic        we, rdy;
    int          wi;
    for (int w = 0; w < 16; w++) drive(32'(w * 4), 1, $urandom, 0);
    drive(32'h3FC, 1, $urandom, 0);
    for (int it = 0; it < 400; it++) begin
      wi = $urandom_range(0, 16);
      if (wi == 16) wi = RAM_WORDS - 1;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 32'(wi * 4);
        4:          a = 32'(wi * 4) + 32'($urandom_range(1, 3));
        5:          a = BASE;
        6:          a = BASE + 4;
        7:          a = BASE + 8;
        8:          a = BASE + 12;
        default: begin
          case ($urandom_range(0, 2))
            0:       a = BASE + 16;
            1:       a = 32'h2000;
            default: a = RAM_WORDS * 4;
          endcase
        end
      endcase
      we  = 1'($urandom_range(0, 1));
      rdy = 1'($urandom_range(0, 1));
      wd  = $urandom;
      drive(a, we, wd, rdy);
      n_checks++;
      if (mem_read !== exp_read(a)) begin
        n_fail++; $display("FAIL rnd_read[%0d] addr=%h got=%h exp=%h", it, a, mem_read, exp_read(a));
      end
      n_checks++;
      if (tx_valid !== (m_q.size() != 0)) begin
        n_fail++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", it, tx_valid, (m_q.size() != 0));
      end else if (m_q.size() != 0) begin
        n_checks++;
        if (tx_data !== m_q[0]) begin n_fail++; $display("FAIL rnd_data[%0d] got=%h exp=%h", it, tx_data, m_q[0]); end
      end
      n_checks++;
      if (gpio_out !== m_gpio || bus_fault !== m_flt) begin
        n_fail++; $display("FAIL rnd_regs[%0d] got=%h/%b exp=%h/%b", it, gpio_out, bus_fault, m_gpio, m_flt);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(BASE + 12, 1, 32'h1234_5678, 0);
    drive(BASE, 1, 32'h55, 0);
    drive(32'h0, 0, 0, 0);
    n_checks++;
    if (gpio_out !== 32'h1234_5678 || tx_valid !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset got=%h/%b exp=12345678/1", gpio_out, tx_valid);
    end
    // Still well before the next rising edge.
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL async_tx_valid got=%b exp=0", tx_valid); end
    n_checks++;
    if (gpio_out !== 32'h0) begin n_fail++; $display("FAIL async_gpio got=%h exp=0", gpio_out); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_ram();
    test_tx_basic();
    test_overflow();
    test_full_pushpop();
    test_fault();
    test_cycle();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_dmem_mmio.md
Name: mips_dmem_mmio

Overview:
- Data-side responder for the single-cycle MIPS core (mips_scp). It answers every load/store the core issues on its mem_addr/mem_write/mem_we/mem_read interface.
- Contains word-addressed data RAM plus a small MMIO window: console TX FIFO, status register, cycle counter, GPIO output register.
- Replaces the behavioural dram model in benches and synthesises as the top-level data memory next to the core.

Parameters:
- RAM_WORDS, 256, data RAM depth in 32-bit words; power of 2.
- FIFO_DEPTH, 8, console TX FIFO entries; power of 2, at least 2.
- MMIO_BASE, 32'h0000_FF00, byte base address of the MMIO window; 256-byte aligned.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_addr  in  32  byte address from core.
- mem_write  in  32  store data from core.
- mem_we  in  1  store strobe; a write commits at the next rising edge of clk.
- mem_read  out  32  load data, combinational from mem_addr.
- tx_data  out  8  console byte at FIFO head.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts head when tx_valid && tx_ready.
- gpio_out  out  32  GPIO register value.
- bus_fault  out  1  sticky fault flag, mirrors STATUS[9].

Behaviour:
- Reset (async, rst_n=0): FIFO empty, tx_valid=0, gpio_out=0, cycle counter=0, overflow and fault flags=0. RAM contents are not reset.
- Address decode:
  - RAM when mem_addr < RAM_WORDS*4; index = mem_addr[log2(RAM_WORDS)+1:2].
  - MMIO registers at MMIO_BASE+offset, listed below.
  - Any other address: unmapped.
- Alignment: mem_addr[1:0]!=0 with mem_we=1 -> write dropped, fault set. A misaligned read returns the word at the aligned address and sets no flag.
- Reads are combinational with zero latency, so the core's single-cycle load sees data in the same cycle. Unmapped reads return 0.
- Writes commit on the rising edge when mem_we=1. Unmapped write -> dropped, fault set.
- MMIO map:
  - +0x00 TX: a write pushes mem_write[7:0]; reads return 0.
  - +0x04 STATUS (read-only fields): [3:0]=count, [4]=empty, [5]=full, [8]=overflow, [9]=fault, other bits 0.
  - STATUS write is write-1-to-clear on bits 8 and 9; all other bits ignored.
  - +0x08 CYCLE: 32-bit counter, increments every cycle and wraps at 0xFFFF_FFFF->0. Any write sets it to 0, the increment is suppressed that cycle, and it reads 0 in the following cycle.
  - +0x0C GPIO: read/write, full 32 bits.
- FIFO:
  - Push when full is dropped and sets overflow; contents are unchanged.
  - Pop occurs when tx_valid && tx_ready.
  - Push and pop in the same cycle: both happen, count unchanged. This also applies when full, so no overflow is flagged.
  - tx_data is driven from the head entry. It holds stable while tx_valid=1 && tx_ready=0.
  - Empty: tx_valid=0. tx_ready is ignored and count stays 0.
- Sticky flags:
  - Set has priority over a W1C clear in the same cycle.
  - Flags are cleared only by W1C or reset.
- Reset asserted mid-stream: FIFO contents are discarded and tx_valid drops asynchronously.

Decomposition:
- Package mips_mem_pkg:
  - MMIO offset constants TX/STATUS/CYCLE/GPIO.
  - STATUS bit-position constants.
  - RAM/MMIO region decode enum.
- One sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/count, async active-low reset), instantiated as the TX FIFO.

Test Plan:
- Store 0x14 to addr 0x0, then load addr 0x0 -> mem_read=0x00000014 in the same cycle as the load; 0x8 to addr 0x4 likewise.
- Store 'H','i' to 0xFF00 with tx_ready=0 -> STATUS reads count=2, empty=0. Raise tx_ready -> tx_data 0x48 then 0x69 on consecutive cycles, then tx_valid=0.
- Push 9 bytes with tx_ready=0 -> STATUS=0x0000_0128 (count=8, full, overflow), first 8 bytes drained intact. Write 0x100 to 0xFF04 -> overflow cleared.
- Full FIFO, push with tx_ready=1 in the same cycle -> count stays 8, overflow remains 0.
- Store to 0x2000, and separately a misaligned store to 0x6 -> bus_fault=1, RAM word 1 unchanged; load 0x2000 -> 0.
- Write 0xFF08 -> CYCLE reads 0 next cycle and 5 five cycles later. Assert rst_n low mid-stream -> tx_valid=0 and gpio_out=0 immediately, without a clock edge.
